// File: rtl/req_ack_responder.sv
// Responder side of a single-bit req/ack handshake: every accepted request is
// answered in order with one ack pulse carrying its tag, no earlier than LATENCY cycles.
module req_ack_responder #(
    parameter int LATENCY     = 1,
    parameter int MAX_PENDING = 4,
    parameter int TAG_W       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req,
    input  logic [TAG_W-1:0]                 req_tag,
    input  logic                             stall,
    output logic                             ack,
    output logic [TAG_W-1:0]                 ack_tag,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             overflow
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int AW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [AW-1:0] LAT_A    = AW'(LATENCY);
    localparam logic [AW-1:0] AGE_INIT = (LATENCY > 0) ? AW'(1) : AW'(0);
    localparam logic [CW-1:0] MAXP     = CW'(MAX_PENDING);
    localparam logic [PW-1:0] LASTP    = PW'(MAX_PENDING - 1);

    logic [TAG_W-1:0] tag_q [MAX_PENDING];
    logic [AW-1:0]    age_q [MAX_PENDING];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic head_valid_s, head_elig_s, bypass_s, deq_s, space_s, enq_s, drop_s;

    // Handshake decisions for this cycle; only bypass looks at req combinationally.
    always_comb begin
        head_valid_s = (count_q != '0);
        head_elig_s  = (LATENCY == 0) || (age_q[rd_ptr_q] >= LAT_A);
        bypass_s     = (LATENCY == 0) && !rst && req && !stall && !head_valid_s;
        deq_s        = !rst && head_valid_s && head_elig_s && !stall;
        space_s      = (count_q < MAXP) || deq_s;
        enq_s        = !rst && req && !bypass_s && space_s;
        drop_s       = !rst && req && !bypass_s && !space_s;
    end

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop_s;
        if (deq_s) begin
            rd_ptr_d = (rd_ptr_q == LASTP) ? '0 : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (enq_s) begin
            wr_ptr_d = (wr_ptr_q == LASTP) ? '0 : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Ack outputs; tag is forced to zero whenever no ack is issued.
    always_comb begin
        ack = bypass_s | deq_s;
        if (bypass_s) begin
            ack_tag = req_tag;
        end else if (deq_s) begin
            ack_tag = tag_q[rd_ptr_q];
        end else begin
            ack_tag = '0;
        end
    end

    // State registers; ages count on every slot and saturate at LATENCY.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                tag_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < MAX_PENDING; i++) begin
                if (age_q[i] < LAT_A) begin
                    age_q[i] <= age_q[i] + AW'(1);
                end else begin
                    age_q[i] <= age_q[i];
                end
            end
            if (enq_s) begin
                tag_q[wr_ptr_q] <= req_tag;
                age_q[wr_ptr_q] <= AGE_INIT;
            end
        end
    end

    assign pending  = count_q;
    assign overflow = overflow_q;

endmodule
